// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_JUMP, S_MDU
  } state_t;

  // C_NOP must stay first so an all-zero register reads as NOP.
  typedef enum logic [4:0] {
    C_NOP, C_ADDU, C_SUBU, C_JR, C_MULT, C_MULTU, C_DIV, C_DIVU, C_MFHI,
    C_MFLO, C_ORI, C_LW, C_SW, C_LUI, C_BEQ, C_JAL, C_ADDIU, C_J
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ   = 6'h04, OP_ADDIU = 6'h09, OP_ORI = 6'h0D,
                         OP_LUI   = 6'h0F, OP_LW  = 6'h23, OP_SW  = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08, FN_MFHI = 6'h10, FN_MFLO = 6'h12,
                         FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A,
                         FN_DIVU = 6'h1B, FN_ADDU = 6'h21, FN_SUBU = 6'h23;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001,
                         ALU_OR  = 4'b0011, ALU_LUI = 4'b0101;

  localparam logic [1:0] NPC_PC4 = 2'd0, NPC_BR = 2'd1, NPC_JMP = 2'd2, NPC_RS = 2'd3;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
  localparam logic [1:0] RI_ALU = 2'd0, RI_MEM = 2'd1, RI_PC4 = 2'd2, RI_HILO = 2'd3;

  typedef struct packed {
    cls_t       cls;
    logic [3:0] aluop;
    logic       siext;
    logic       alusrc2;
    logic [1:0] mduop;
  } dec_t;

  function automatic logic is_mdu(input cls_t c);
    return c inside {C_MULT, C_MULTU, C_DIV, C_DIVU};
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: class plus the ALU/MDU attributes of that class.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] opcode, funct;
  cls_t       cls;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    cls = C_NOP;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU:  cls = C_ADDU;
          FN_SUBU:  cls = C_SUBU;
          FN_JR:    cls = C_JR;
          FN_MULT:  cls = C_MULT;
          FN_MULTU: cls = C_MULTU;
          FN_DIV:   cls = C_DIV;
          FN_DIVU:  cls = C_DIVU;
          FN_MFHI:  cls = C_MFHI;
          FN_MFLO:  cls = C_MFLO;
          default:  cls = C_NOP;
        endcase
      end
      OP_J:     cls = C_J;
      OP_JAL:   cls = C_JAL;
      OP_BEQ:   cls = C_BEQ;
      OP_ADDIU: cls = C_ADDIU;
      OP_ORI:   cls = C_ORI;
      OP_LUI:   cls = C_LUI;
      OP_LW:    cls = C_LW;
      OP_SW:    cls = C_SW;
      default:  cls = C_NOP;
    endcase
  end

  always_comb begin
    dec     = '0;
    dec.cls = cls;
    case (cls)
      C_SUBU:            dec.aluop = ALU_SUB;
      C_ORI:   begin dec.aluop = ALU_OR;  dec.alusrc2 = 1'b1; end
      C_LUI:   begin dec.aluop = ALU_LUI; dec.alusrc2 = 1'b1; end
      C_ADDIU, C_LW, C_SW: begin
        dec.aluop   = ALU_ADD;
        dec.alusrc2 = 1'b1;
        dec.siext   = 1'b1;
      end
      C_MULT:  dec.mduop = 2'd0;
      C_MULTU: dec.mduop = 2'd1;
      C_DIV:   dec.mduop = 2'd2;
      C_DIVU:  dec.mduop = 2'd3;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM: latches the decoded class in DECODE and sequences
// FETCH/DECODE/EXEC/MEM/WB plus branch, jump and iterative MDU wait states.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        pcWrite,
  output logic        irWrite,
  output logic [1:0]  npcSel,
  output logic        regWrite,
  output logic [1:0]  regDst,
  output logic [1:0]  regIn,
  output logic        siExt,
  output logic        ALUSrc2,
  output logic [3:0]  ALUOP,
  output logic        memWrite,
  output logic        mduStart,
  output logic [1:0]  mduOp,
  output logic        hiloSel,
  output logic        hiloWrite,
  output logic        busy
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

  state_t           state, nstate;
  dec_t             dec_live, dec_q;
  logic [CNT_W-1:0] cnt;
  logic             mdu_first;
  logic             mdu_enter;

  mc_decode u_decode (.instr(instr), .dec(dec_live));

  assign mdu_enter = (state == S_DECODE) && is_mdu(dec_live.cls);

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= nstate;
  end

  // Counter is loaded on the way into MDU so the entry cycle already sees
  // latency-1, letting a 1-cycle latency start and finish together.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q     <= '0;
      cnt       <= '0;
      mdu_first <= 1'b0;
    end else begin
      mdu_first <= mdu_enter;
      if (state == S_DECODE) dec_q <= dec_live;
      if (mdu_enter)
        cnt <= (dec_live.cls inside {C_MULT, C_MULTU}) ? MULT_LD : DIV_LD;
      else if (state == S_MDU && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      S_FETCH:  nstate = S_DECODE;
      S_DECODE: begin
        if (dec_live.cls inside {C_J, C_JAL, C_JR}) nstate = S_JUMP;
        else if (dec_live.cls == C_BEQ)             nstate = S_BRANCH;
        else if (is_mdu(dec_live.cls))              nstate = S_MDU;
        else if (dec_live.cls == C_NOP)             nstate = S_FETCH;
        else                                        nstate = S_EXEC;
      end
      S_EXEC:   nstate = (dec_q.cls inside {C_LW, C_SW}) ? S_MEM : S_WB;
      S_MEM:    nstate = (dec_q.cls == C_LW) ? S_WB : S_FETCH;
      S_WB, S_BRANCH, S_JUMP: nstate = S_FETCH;
      S_MDU:    nstate = (cnt == '0) ? S_FETCH : S_MDU;
      default:  nstate = S_FETCH;
    endcase
  end

  always_comb begin
    pcWrite = 1'b0; irWrite = 1'b0; npcSel = NPC_PC4; regWrite = 1'b0;
    regDst = RD_RT; regIn = RI_ALU; siExt = 1'b0; ALUSrc2 = 1'b0;
    ALUOP = ALU_ADD; memWrite = 1'b0; mduStart = 1'b0; mduOp = 2'd0;
    hiloSel = 1'b0; hiloWrite = 1'b0; busy = 1'b0;
    case (state)
      S_FETCH: begin
        irWrite = 1'b1;
        pcWrite = 1'b1;
      end
      S_EXEC: begin
        ALUOP   = dec_q.aluop;
        ALUSrc2 = dec_q.alusrc2;
        siExt   = dec_q.siext;
      end
      S_MEM: memWrite = (dec_q.cls == C_SW);
      S_WB: begin
        regWrite = 1'b1;
        regDst   = (dec_q.cls inside {C_ADDU, C_SUBU, C_MFHI, C_MFLO}) ? RD_RD : RD_RT;
        if (dec_q.cls == C_LW)                          regIn = RI_MEM;
        else if (dec_q.cls inside {C_MFHI, C_MFLO})     regIn = RI_HILO;
        hiloSel  = (dec_q.cls == C_MFHI);
      end
      S_BRANCH: begin
        ALUOP   = ALU_SUB;
        siExt   = 1'b1;
        npcSel  = NPC_BR;
        pcWrite = zero;
      end
      S_JUMP: begin
        pcWrite = 1'b1;
        npcSel  = (dec_q.cls == C_JR) ? NPC_RS : NPC_JMP;
        if (dec_q.cls == C_JAL) begin
          regWrite = 1'b1;
          regDst   = RD_RA;
          regIn    = RI_PC4;
        end
      end
      S_MDU: begin
        busy      = 1'b1;
        mduOp     = dec_q.mduop;
        mduStart  = mdu_first;
        hiloWrite = (cnt == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed cycle-by-cycle check of every controller strobe per instruction.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        pcWrite, irWrite, regWrite, siExt, ALUSrc2, memWrite;
  logic        mduStart, hiloSel, hiloWrite, busy;
  logic [1:0]  npcSel, regDst, regIn, mduOp;
  logic [3:0]  ALUOP;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero),
    .pcWrite(pcWrite), .irWrite(irWrite), .npcSel(npcSel), .regWrite(regWrite),
    .regDst(regDst), .regIn(regIn), .siExt(siExt), .ALUSrc2(ALUSrc2),
    .ALUOP(ALUOP), .memWrite(memWrite), .mduStart(mduStart), .mduOp(mduOp),
    .hiloSel(hiloSel), .hiloWrite(hiloWrite), .busy(busy)
  );

  logic [21:0] outv;
  assign outv = {pcWrite, irWrite, npcSel, regWrite, regDst, regIn, siExt, ALUSrc2,
                 ALUOP, memWrite, mduStart, mduOp, hiloSel, hiloWrite, busy};

  function automatic logic [21:0] ov(
    input logic pw, iw, input logic [1:0] npc, input logic rw,
    input logic [1:0] rd, ri, input logic se, as, input logic [3:0] aop,
    input logic mw, ms, input logic [1:0] mo, input logic hs, hw, b);
    return {pw, iw, npc, rw, rd, ri, se, as, aop, mw, ms, mo, hs, hw, b};
  endfunction

  task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Check the current cycle (sampled at negedge), then advance one cycle.
  task automatic cyc(input string tag, input logic [21:0] exp);
    chk(tag, outv, exp);
    @(negedge clk);
  endtask

  logic [21:0] F, Z;

  initial begin
    F = ov(1,1,2'd0, 0,2'd0,2'd0, 0,0,4'h0, 0,0,2'd0, 0,0,0);
    Z = '0;
    reset = 1'b1; instr = 32'h0; zero = 1'b0;
    @(negedge clk);
    chk("rst_hold", outv, F);
    @(negedge clk);
    reset = 1'b0;

    instr = 32'h00221821; // addu $3,$1,$2
    cyc("addu_f", F);
    cyc("addu_d", Z);
    cyc("addu_e", Z);
    cyc("addu_wb", ov(0,0,2'd0, 1,2'd1,2'd0, 0,0,4'h0, 0,0,2'd0, 0,0,0));

    instr = 32'h8C220004; // lw
    cyc("lw_f", F);
    cyc("lw_d", Z);
    cyc("lw_e", ov(0,0,2'd0, 0,2'd0,2'd0, 1,1,4'h0, 0,0,2'd0, 0,0,0));
    cyc("lw_m", Z);
    cyc("lw_wb", ov(0,0,2'd0, 1,2'd0,2'd1, 0,0,4'h0, 0,0,2'd0, 0,0,0));

    instr = 32'hAC220004; // sw
    cyc("sw_f", F);
    cyc("sw_d", Z);
    cyc("sw_e", ov(0,0,2'd0, 0,2'd0,2'd0, 1,1,4'h0, 0,0,2'd0, 0,0,0));
    cyc("sw_m", ov(0,0,2'd0, 0,2'd0,2'd0, 0,0,4'h0, 1,0,2'd0, 0,0,0));

    instr = 32'h34221234; // ori
    cyc("ori_f", F);
    cyc("ori_d", Z);
    cyc("ori_e", ov(0,0,2'd0, 0,2'd0,2'd0, 0,1,4'h3, 0,0,2'd0, 0,0,0));
    cyc("ori_wb", ov(0,0,2'd0, 1,2'd0,2'd0, 0,0,4'h0, 0,0,2'd0, 0,0,0));

    instr = 32'h3C011234; // lui
    cyc("lui_f", F);
    cyc("lui_d", Z);
    cyc("lui_e", ov(0,0,2'd0, 0,2'd0,2'd0, 0,1,4'h5, 0,0,2'd0, 0,0,0));
    cyc("lui_wb", ov(0,0,2'd0, 1,2'd0,2'd0, 0,0,4'h0, 0,0,2'd0, 0,0,0));

    instr = 32'h10220003; zero = 1'b1; // beq taken
    cyc("beq1_f", F);
    cyc("beq1_d", Z);
    cyc("beq1_b", ov(1,0,2'd1, 0,2'd0,2'd0, 1,0,4'h1, 0,0,2'd0, 0,0,0));
    zero = 1'b0; // beq not taken
    cyc("beq0_f", F);
    cyc("beq0_d", Z);
    cyc("beq0_b", ov(0,0,2'd1, 0,2'd0,2'd0, 1,0,4'h1, 0,0,2'd0, 0,0,0));

    instr = 32'h0C000010; // jal
    cyc("jal_f", F);
    cyc("jal_d", Z);
    cyc("jal_j", ov(1,0,2'd2, 1,2'd2,2'd2, 0,0,4'h0, 0,0,2'd0, 0,0,0));

    instr = 32'h03E00008; // jr $31
    cyc("jr_f", F);
    cyc("jr_d", Z);
    cyc("jr_j", ov(1,0,2'd3, 0,2'd0,2'd0, 0,0,4'h0, 0,0,2'd0, 0,0,0));

    instr = 32'h00220019; // multu
    cyc("multu_f", F);
    cyc("multu_d", Z);
    cyc("multu_1", ov(0,0,2'd0, 0,2'd0,2'd0, 0,0,4'h0, 0,1,2'd1, 0,0,1));
    for (int i = 2; i <= 4; i++)
      cyc($sformatf("multu_%0d", i), ov(0,0,2'd0, 0,2'd0,2'd0, 0,0,4'h0, 0,0,2'd1, 0,0,1));
    cyc("multu_5", ov(0,0,2'd0, 0,2'd0,2'd0, 0,0,4'h0, 0,0,2'd1, 0,1,1));

    instr = 32'h0022001A; // div
    cyc("div_f", F);
    cyc("div_d", Z);
    cyc("div_1", ov(0,0,2'd0, 0,2'd0,2'd0, 0,0,4'h0, 0,1,2'd2, 0,0,1));
    for (int i = 2; i <= 9; i++)
      cyc($sformatf("div_%0d", i), ov(0,0,2'd0, 0,2'd0,2'd0, 0,0,4'h0, 0,0,2'd2, 0,0,1));
    cyc("div_10", ov(0,0,2'd0, 0,2'd0,2'd0, 0,0,4'h0, 0,0,2'd2, 0,1,1));

    instr = 32'h00001810; // mfhi $3
    cyc("mfhi_f", F);
    cyc("mfhi_d", Z);
    cyc("mfhi_e", Z);
    cyc("mfhi_wb", ov(0,0,2'd0, 1,2'd1,2'd3, 0,0,4'h0, 0,0,2'd0, 1,0,0));

    instr = 32'h0022001A; // div interrupted by reset
    cyc("rdiv_f", F);
    cyc("rdiv_d", Z);
    cyc("rdiv_1", ov(0,0,2'd0, 0,2'd0,2'd0, 0,0,4'h0, 0,1,2'd2, 0,0,1));
    for (int i = 2; i <= 3; i++)
      cyc($sformatf("rdiv_%0d", i), ov(0,0,2'd0, 0,2'd0,2'd0, 0,0,4'h0, 0,0,2'd2, 0,0,1));
    chk("rdiv_4", outv, ov(0,0,2'd0, 0,2'd0,2'd0, 0,0,4'h0, 0,0,2'd2, 0,0,1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    instr = 32'hFC000000; // opcode 0x3F -> NOP
    cyc("rst_f", F);
    cyc("nop_d", Z);
    cyc("nop_f", F);
    cyc("nop2_d", Z);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
